multicycle_ctrl: RTL and testbench

- Multi-cycle sequencer for the RV32I core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB.
- It drives the instruction- and data-memory request handshakes, the IR, register-file and PC write enables, and the PC source select.
- It captures the ALU branch decision (br_taken) in EXEC and applies it in WB.
- It counts retired instructions and traps illegal instructions and memory timeouts into a sticky FAULT state.

---
 rtl/multicycle_ctrl_if.sv | 29 ++
 rtl/multicycle_ctrl.sv | 84 ++++++++
 tb/tb_multicycle_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - memory handshake, decode and strobe bundle of the sequencer
interface multicycle_ctrl_if;
    logic imem_req;
    logic imem_ack;
    logic ir_we;
    logic dec_is_load;
    logic dec_is_store;
    logic dec_no_wb;
    logic dec_illegal;
    logic br_taken;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ack;
    logic rf_we;
    logic pc_we;
    logic pc_sel;

    modport master (
        output imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel,
        input  imem_ack, dmem_ack, dec_is_load, dec_is_store, dec_no_wb,
               dec_illegal, br_taken
    );

    modport slave (
        input  imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel,
        output imem_ack, dmem_ack, dec_is_load, dec_is_store, dec_no_wb,
               dec_illegal, br_taken
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with fault trap
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    multicycle_ctrl_if.master     bus,
    output logic                  fault,
    output logic [2:0]            state,
    output logic [CNT_W-1:0]      instret
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    // Timer only has to count up to MEM_TIMEOUT-1 before the fault decision.
    localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LIMIT = TW'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);

    state_t          state_q;
    state_t          state_d;
    logic            br_q;
    logic [TW-1:0]   timer_q;
    logic            waiting;
    logic            timed_out;

    assign waiting   = (state_q == S_FETCH) || (state_q == S_MEM);
    assign timed_out = (MEM_TIMEOUT != 0) && (timer_q == T_LIMIT);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (run) state_d = S_FETCH;
            // An ack on the limit cycle takes priority over the timeout.
            S_FETCH: begin
                if (bus.imem_ack)   state_d = S_DECODE;
                else if (timed_out) state_d = S_FAULT;
            end
            S_DECODE: state_d = bus.dec_illegal ? S_FAULT : S_EXEC;
            S_EXEC:   state_d = (bus.dec_is_load || bus.dec_is_store) ? S_MEM : S_WB;
            S_MEM: begin
                if (bus.dmem_ack)   state_d = S_WB;
                else if (timed_out) state_d = S_FAULT;
            end
            S_WB:     state_d = run ? S_FETCH : S_IDLE;
            S_FAULT:  state_d = S_FAULT;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            br_q    <= 1'b0;
            timer_q <= '0;
            instret <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_EXEC) br_q <= bus.br_taken;
            if (state_q == S_WB)   instret <= instret + 1'b1;
            // Staying in a wait state means no ack yet; any transition restarts the count.
            if (waiting && (state_d == state_q)) timer_q <= timer_q + 1'b1;
            else                                 timer_q <= '0;
        end
    end

    assign bus.imem_req = (state_q == S_FETCH);
    assign bus.ir_we    = (state_q == S_FETCH) && bus.imem_ack;
    assign bus.dmem_req = (state_q == S_MEM);
    assign bus.dmem_we  = (state_q == S_MEM) && bus.dec_is_store;
    assign bus.rf_we    = (state_q == S_WB) && !bus.dec_no_wb;
    assign bus.pc_we    = (state_q == S_WB);
    assign bus.pc_sel   = (state_q == S_WB) && br_q;
    assign fault        = (state_q == S_FAULT);
    assign state        = state_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed table and corner-case sequences for multicycle_ctrl
module tb_multicycle_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic       fault;
    logic [2:0] state;
    logic [3:0] instret;

    multicycle_ctrl_if bus();

    multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (run),
        .bus     (bus),
        .fault   (fault),
        .state   (state),
        .instret (instret)
    );

    always #5 clk = ~clk;

    // in  = {run, imem_ack, dmem_ack, is_load, is_store, no_wb, illegal, br_taken}
    // out = {imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel, fault}
    typedef struct {
        logic [7:0] in;
        logic [2:0] st;
        logic [7:0] out;
        logic [3:0] n;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad = 0;

    task automatic add(input logic [7:0] i, input logic [2:0] s, input logic [7:0] o, input logic [3:0] n);
        vec_t v;
        v.in = i; v.st = s; v.out = o; v.n = n;
        vecs.push_back(v);
    endtask

    task automatic set_in(input logic [7:0] v);
        {run, bus.imem_ack, bus.dmem_ack, bus.dec_is_load, bus.dec_is_store,
         bus.dec_no_wb, bus.dec_illegal, bus.br_taken} = v;
    endtask

    function automatic logic [7:0] outs();
        return {bus.imem_req, bus.ir_we, bus.dmem_req, bus.dmem_we,
                bus.rf_we, bus.pc_we, bus.pc_sel, fault};
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%h want=%h", name, idx, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        set_in(8'h00);
        #1 chk("reset", 0, {state, outs(), instret}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int rf_cnt;
    int pc_cnt;

    initial begin
        add(8'b1100_0000, 3'd0, 8'h00, 4'd0);
        for (int k = 0; k < 3; k++) begin
            add(8'b1100_0000, 3'd1, 8'b1100_0000, 4'(k));
            add(8'b1100_0000, 3'd2, 8'h00,        4'(k));
            add(8'b1100_0000, 3'd3, 8'h00,        4'(k));
            add(8'b1100_0000, 3'd5, 8'b0000_1100, 4'(k));
        end
        // load, dmem_ack on the 4th MEM cycle
        add(8'b1101_0000, 3'd1, 8'b1100_0000, 4'd3);
        add(8'b1101_0000, 3'd2, 8'h00,        4'd3);
        add(8'b1101_0000, 3'd3, 8'h00,        4'd3);
        add(8'b1101_0000, 3'd4, 8'b0010_0000, 4'd3);
        add(8'b1101_0000, 3'd4, 8'b0010_0000, 4'd3);
        add(8'b1101_0000, 3'd4, 8'b0010_0000, 4'd3);
        add(8'b1111_0000, 3'd4, 8'b0010_0000, 4'd3);
        add(8'b1101_0000, 3'd5, 8'b0000_1100, 4'd3);
        // store
        add(8'b1100_1100, 3'd1, 8'b1100_0000, 4'd4);
        add(8'b1100_1100, 3'd2, 8'h00,        4'd4);
        add(8'b1100_1100, 3'd3, 8'h00,        4'd4);
        add(8'b1110_1100, 3'd4, 8'b0011_0000, 4'd4);
        add(8'b1100_1100, 3'd5, 8'b0000_0100, 4'd4);
        // taken branch: br_taken high in EXEC only
        add(8'b1100_0100, 3'd1, 8'b1100_0000, 4'd5);
        add(8'b1100_0100, 3'd2, 8'h00,        4'd5);
        add(8'b1100_0101, 3'd3, 8'h00,        4'd5);
        add(8'b1100_0100, 3'd5, 8'b0000_0110, 4'd5);
        // not-taken branch with run dropped mid-instruction
        add(8'b0100_0100, 3'd1, 8'b1100_0000, 4'd6);
        add(8'b0100_0100, 3'd2, 8'h00,        4'd6);
        add(8'b0100_0100, 3'd3, 8'h00,        4'd6);
        add(8'b0100_0101, 3'd5, 8'b0000_0100, 4'd6);
        add(8'b0110_0000, 3'd0, 8'h00,        4'd7);
        add(8'b0110_0000, 3'd0, 8'h00,        4'd7);

        do_reset();
        foreach (vecs[i]) begin
            set_in(vecs[i].in);
            #1 chk("vec", i, {state, outs(), instret}, {vecs[i].st, vecs[i].out, vecs[i].n});
            @(negedge clk);
        end

        // fetch ack on the 4th FETCH cycle is accepted
        do_reset();
        set_in(8'b1000_0000);
        @(negedge clk);
        for (int c = 1; c <= 3; c++) begin
            #1 chk("late_ack_wait", c, {state, outs()}, {3'd1, 8'b1000_0000});
            @(negedge clk);
        end
        set_in(8'b1100_0000);
        #1 chk("late_ack_last", 4, {state, outs()}, {3'd1, 8'b1100_0000});
        @(negedge clk);
        set_in(8'b1000_0000);
        #1 chk("late_ack_decode", 0, {state, outs()}, {3'd2, 8'h00});

        // fetch timeout into sticky fault
        do_reset();
        set_in(8'b1000_0000);
        @(negedge clk);
        for (int c = 1; c <= 4; c++) begin
            #1 chk("timeout_wait", c, {state, outs()}, {3'd1, 8'b1000_0000});
            @(negedge clk);
        end
        set_in(8'b1110_0000);
        for (int c = 0; c < 3; c++) begin
            #1 chk("fault_hold", c, {state, outs()}, {3'd6, 8'b0000_0001});
            @(negedge clk);
        end
        do_reset();
        #1 chk("fault_cleared", 0, {state, outs()}, {3'd0, 8'h00});

        // illegal opcode after one retired instruction
        do_reset();
        rf_cnt = 0;
        pc_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            set_in(i >= 5 ? 8'b1100_0010 : 8'b1100_0000);
            #1;
            rf_cnt += int'(bus.rf_we);
            pc_cnt += int'(bus.pc_we);
            @(negedge clk);
        end
        #1 chk("illegal_state", 0, {state, fault}, {3'd6, 1'b1});
        chk("illegal_rf_we", 0, rf_cnt, 1);
        chk("illegal_pc_we", 0, pc_cnt, 1);
        chk("illegal_instret", 0, instret, 4'd1);

        // async reset in the middle of a load
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_in(i >= 4 ? 8'b1101_0000 : 8'b1100_0000);
            @(negedge clk);
        end
        #1 chk("mid_mem", 0, {state, bus.dmem_req, instret}, {3'd4, 1'b1, 4'd1});
        #2 rst_n = 1'b0;
        #1 chk("mid_mem_reset", 0, {state, bus.dmem_req, instret}, {3'd0, 1'b0, 4'd0});
        @(negedge clk);
        rst_n = 1'b1;

        // instret wraps from all-ones to zero
        do_reset();
        set_in(8'b1100_0000);
        for (int j = 0; j <= 65; j++) begin
            #1;
            if (j == 61) chk("wrap_max", j, {state, instret}, {3'd1, 4'hF});
            if (j == 65) chk("wrap_zero", j, {state, instret}, {3'd1, 4'h0});
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
